// File: rtl/ctrl_hazard_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_hazard_pipe
//   Carries LEGv8 decoder control bits from ID through the ID/EX, EX/MEM and
//   MEM/WB pipeline registers. It also:
//     - detects load-use hazards and requests a stall, inserting a bubble;
//     - squashes the ID and EX instructions when MEM resolves a taken branch;
//     - keeps saturating stall and flush event counters for debug.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_valid              IF/ID holds a real instruction
//   id_ctrl[8:0]          {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,
//                          Branch,ALUOp[1:0]}
//   id_rn, id_rs2, id_rd  source and destination register indices in ID
//   mem_branch_taken      Branch & Zero, evaluated in MEM this cycle
//   stall, flush          hazard controls (combinational)
//   ex_alusrc, ex_aluop   ID/EX control
//   mem_memread, mem_memwrite, mem_branch   EX/MEM control
//   wb_memtoreg, wb_regwrite                MEM/WB control
//   ex_rd, mem_rd, wb_rd  destination index per stage (XZR when empty)
//   stall_cnt, flush_cnt  saturating event counters
// ---------------------------------------------------------------------------
module ctrl_hazard_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [8:0]       id_ctrl,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_branch,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_W-1:0] XZR     = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ID/EX control layout:  [7] ALUSrc [6] MemtoReg [5] RegWrite [4] MemRead
  //                        [3] MemWrite [2] Branch [1:0] ALUOp
  // EX/MEM control layout: [4] MemtoReg [3] RegWrite [2] MemRead [1] MemWrite
  //                        [0] Branch
  // MEM/WB control layout: [1] MemtoReg [0] RegWrite
  logic             r_vld_p0, r_vld_p1, r_vld_p2;
  logic [7:0]       r_ctrl_p0;
  logic [4:0]       r_ctrl_p1;
  logic [1:0]       r_ctrl_p2;
  logic [REG_W-1:0] r_rd_p0, r_rd_p1, r_rd_p2;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             r_rst_q;

  logic w_uses_rn, w_uses_rs2, w_haz, w_quiet;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             ev);
    if (ev && cnt != CNT_MAX) return cnt + 1'b1;
    return cnt;
  endfunction

  // CBZ (ALUOp=01) does not read Rn; Rt is read by stores/CBZ via Reg2Loc,
  // Rm by R-type (ALUOp=10).
  assign w_uses_rn  = id_valid & (id_ctrl[1:0] != 2'b01);
  assign w_uses_rs2 = id_valid & (id_ctrl[8] | (id_ctrl[1:0] == 2'b10));

  assign w_haz = r_vld_p0 & r_ctrl_p0[4] & (r_rd_p0 != XZR)
               & ((w_uses_rn  & (r_rd_p0 == id_rn))
                | (w_uses_rs2 & (r_rd_p0 == id_rs2)));

  // Hazard controls are held low in the reset cycle and the one after it,
  // so a stale branch-taken from the datapath cannot squash fresh fetches.
  assign w_quiet = reset | r_rst_q;
  assign flush   = mem_branch_taken & ~w_quiet;
  assign stall   = w_haz & ~flush & ~w_quiet;

  always_ff @(posedge clk) begin
    r_rst_q <= reset;
    if (reset) begin
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_ctrl_p0   <= '0;
      r_ctrl_p1   <= '0;
      r_ctrl_p2   <= '0;
      r_rd_p0     <= XZR;
      r_rd_p1     <= XZR;
      r_rd_p2     <= XZR;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, stall);
      r_flush_cnt <= sat_inc(r_flush_cnt, flush);

      // MEM/WB always takes EX/MEM, so a taken branch itself still retires
      r_vld_p2  <= r_vld_p1;
      r_ctrl_p2 <= r_ctrl_p1[4:3];
      r_rd_p2   <= r_rd_p1;

      if (flush) begin
        // EX/MEM: squash the instruction that was in EX
        r_vld_p1  <= 1'b0;
        r_ctrl_p1 <= '0;
        r_rd_p1   <= XZR;
        // ID/EX: squash the instruction that was in ID
        r_vld_p0  <= 1'b0;
        r_ctrl_p0 <= '0;
        r_rd_p0   <= XZR;
      end else begin
        // EX/MEM
        r_vld_p1  <= r_vld_p0;
        r_ctrl_p1 <= r_ctrl_p0[6:2];
        r_rd_p1   <= r_rd_p0;
        // ID/EX: bubble on stall or empty ID slot
        if (stall || !id_valid) begin
          r_vld_p0  <= 1'b0;
          r_ctrl_p0 <= '0;
          r_rd_p0   <= XZR;
        end else begin
          r_vld_p0  <= 1'b1;
          r_ctrl_p0 <= id_ctrl[7:0];
          r_rd_p0   <= id_rd;
        end
      end
    end
  end

  assign ex_alusrc    = r_vld_p0 & r_ctrl_p0[7];
  assign ex_aluop     = r_vld_p0 ? r_ctrl_p0[1:0] : 2'b00;
  assign mem_memread  = r_vld_p1 & r_ctrl_p1[2];
  assign mem_memwrite = r_vld_p1 & r_ctrl_p1[1];
  assign mem_branch   = r_vld_p1 & r_ctrl_p1[0];
  assign wb_memtoreg  = r_vld_p2 & r_ctrl_p2[1];
  assign wb_regwrite  = r_vld_p2 & r_ctrl_p2[0];
  assign ex_rd        = r_rd_p0;
  assign mem_rd       = r_rd_p1;
  assign wb_rd        = r_rd_p2;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Self-checking bench for ctrl_hazard_pipe: directed LEGv8 sequences plus
// randomized traffic, compared against a pipeline model kept as an array of
// instruction records.
module tb_ctrl_hazard_pipe;
  localparam int REG_W = 5;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int XZR   = (1 << REG_W) - 1;

  localparam logic [8:0] C_LDUR = 9'h0F0; // ALUSrc MemtoReg RegWrite MemRead
  localparam logic [8:0] C_ADD  = 9'h022; // RegWrite, ALUOp=10
  localparam logic [8:0] C_STUR = 9'h188; // Reg2Loc ALUSrc MemWrite
  localparam logic [8:0] C_CBZ  = 9'h105; // Reg2Loc Branch ALUOp=01

  logic             clk = 1'b0;
  logic             reset, id_valid, mem_branch_taken;
  logic [8:0]       id_ctrl;
  logic [REG_W-1:0] id_rn, id_rs2, id_rd;
  logic             stall, flush, ex_alusrc, mem_memread, mem_memwrite, mem_branch;
  logic             wb_memtoreg, wb_regwrite;
  logic [1:0]       ex_aluop;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ctrl_hazard_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rn(id_rn), .id_rs2(id_rs2), .id_rd(id_rd),
    .mem_branch_taken(mem_branch_taken), .stall(stall), .flush(flush),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [8:0] c;
    int       rd;
  } instr_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t pipe [3];
  int     m_scnt, m_fcnt;
  bit     m_rst_prev;
  int     n_cmp, n_err;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.v = 0; b.c = '0; b.rd = XZR;
    return b;
  endfunction

  function automatic bit model_hazard();
    bit rd_rn, rd_rs2;
    instr_t e = pipe[0];
    rd_rn  = id_valid && (id_ctrl[1:0] != 2'b01);
    rd_rs2 = id_valid && (id_ctrl[8] || id_ctrl[1:0] == 2'b10);
    return e.v && e.c[4] && e.rd != XZR &&
           ((rd_rn && e.rd == int'(id_rn)) || (rd_rs2 && e.rd == int'(id_rs2)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    m_scnt = 0; m_fcnt = 0;
  endtask

  // One cycle: apply inputs, check stall/flush, clock, check registered outputs.
  task automatic step(input bit rst, input bit v, input logic [8:0] c,
                      input int rn, input int rs2, input int rd, input bit br);
    bit e_fl, e_st;
    instr_t nw;
    reset = rst; id_valid = v; id_ctrl = c;
    id_rn = REG_W'(rn); id_rs2 = REG_W'(rs2); id_rd = REG_W'(rd);
    mem_branch_taken = br;
    #1;
    e_fl = !rst && !m_rst_prev && br;
    e_st = !rst && !m_rst_prev && !e_fl && model_hazard();
    chk("flush", flush, e_fl);
    chk("stall", stall, e_st);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (e_st && m_scnt < CMAX) m_scnt++;
      if (e_fl && m_fcnt < CMAX) m_fcnt++;
      pipe[2] = pipe[1];
      if (e_fl) begin
        pipe[1] = bubble(); pipe[0] = bubble();
      end else begin
        pipe[1] = pipe[0];
        if (e_st || !v) pipe[0] = bubble();
        else begin
          nw.v = 1; nw.c = c; nw.rd = rd; pipe[0] = nw;
        end
      end
    end
    m_rst_prev = rst;
    #1;
    chk("ex_alusrc",    ex_alusrc,    pipe[0].v & pipe[0].c[7]);
    chk("ex_aluop",     ex_aluop,     pipe[0].v ? pipe[0].c[1:0] : 0);
    chk("mem_memread",  mem_memread,  pipe[1].v & pipe[1].c[4]);
    chk("mem_memwrite", mem_memwrite, pipe[1].v & pipe[1].c[3]);
    chk("mem_branch",   mem_branch,   pipe[1].v & pipe[1].c[2]);
    chk("wb_memtoreg",  wb_memtoreg,  pipe[2].v & pipe[2].c[6]);
    chk("wb_regwrite",  wb_regwrite,  pipe[2].v & pipe[2].c[5]);
    chk("ex_rd",  ex_rd,  pipe[0].rd);
    chk("mem_rd", mem_rd, pipe[1].rd);
    chk("wb_rd",  wb_rd,  pipe[2].rd);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
    @(negedge clk);
  endtask

  int r_sel [4] = '{0, 1, 5, 31};

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1; id_valid = 0; id_ctrl = '0; id_rn = '0; id_rs2 = '0; id_rd = '0;
    mem_branch_taken = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    m_rst_prev = 1;

    // Reset cycle with branch-taken high: stall/flush must stay low
    step(1, 1, C_LDUR, 0, 0, 1, 1);
    step(0, 0, 9'h0, 0, 0, 0, 1);
    chk("rst_wb_rd", wb_rd, XZR);
    chk("rst_flush_cnt", flush_cnt, 0);

    // Load-use: LDUR X1 then ADD X2,X1,X3 -> one stall, bubble, then ADD
    step(0, 1, C_LDUR, 0, 0, 1, 0);
    step(0, 1, C_ADD, 1, 3, 2, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    step(0, 1, C_ADD, 1, 3, 2, 0);
    chk("lu_ex_aluop", ex_aluop, 2'b10);
    // LDUR X31 then reader of X31 -> no stall
    step(0, 1, C_LDUR, 0, 0, 31, 0);
    step(0, 1, C_ADD, 31, 31, 4, 0);
    // CBZ X5 (rs2 path) behind LDUR X5 -> stall; CBZ X0 -> none
    step(0, 1, C_LDUR, 0, 0, 5, 0);
    step(0, 1, C_CBZ, 5, 5, 31, 0);
    step(0, 1, C_CBZ, 5, 5, 31, 0);
    step(0, 1, C_LDUR, 0, 0, 5, 0);
    step(0, 1, C_CBZ, 5, 0, 31, 0);
    // Flush beats a would-be stall
    step(0, 1, C_LDUR, 0, 0, 1, 0);
    step(0, 1, C_ADD, 1, 3, 2, 1);
    chk("fl_ex_aluop", ex_aluop, 0);
    // Streamed ADD, LDUR, STUR with no hazards
    step(0, 1, C_ADD, 2, 3, 4, 0);
    step(0, 1, C_LDUR, 6, 0, 7, 0);
    step(0, 1, C_STUR, 8, 9, 31, 0);
    step(0, 0, 9'h0, 0, 0, 0, 0);
    chk("st_mem_memwrite", mem_memwrite, 1);
    chk("st_wb_memtoreg", wb_memtoreg, 1);

    // Saturate the stall counter
    for (int i = 0; i < CMAX + 3; i++) begin
      step(0, 1, C_LDUR, 0, 0, 1, 0);
      step(0, 1, C_ADD, 1, 3, 2, 0);
    end
    chk("sat_stall_cnt", stall_cnt, CMAX);

    // Reset mid-stream
    step(0, 1, C_LDUR, 0, 0, 3, 0);
    step(1, 1, C_ADD, 3, 3, 4, 0);
    chk("mid_rst_ex_rd", ex_rd, XZR);
    chk("mid_rst_stall_cnt", stall_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) != 0),
           9'($urandom),
           r_sel[$urandom_range(0, 3)], r_sel[$urandom_range(0, 3)],
           r_sel[$urandom_range(0, 3)],
           ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
